// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the two-digit 7-segment scan controller.
// Segment vectors are packed {g,f,e,d,c,b,a}, active-high unless inverted at the pins.
package seven_seg_pkg;

  localparam int unsigned SEG_W = 7;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  localparam logic [SEG_W-1:0] SEG_ALL_OFF = 7'h00;

  // Hex glyphs 0..F, lower-case b and d so they differ from 8 and 0
  localparam logic [SEG_W-1:0] HEX_SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    GUARD = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic [3:0] d1;
    logic [3:0] d0;
  } digit_pair_t;

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational hex-to-segment decoder with selectable output polarity.
module seven_seg_hex_decode
  import seven_seg_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic [3:0]       digit,
  output logic [SEG_W-1:0] seg_c
);

  logic [SEG_W-1:0] lit_c;

  // Table lookup, then place segments in pin order and apply polarity
  always_comb begin
    lit_c = HEX_SEG_TABLE[digit];
    seg_c = {lit_c[SEG_G], lit_c[SEG_F], lit_c[SEG_E], lit_c[SEG_D],
             lit_c[SEG_C], lit_c[SEG_B], lit_c[SEG_A]};
    if (SEG_ACTIVE_LOW) begin
      seg_c = ~seg_c;
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Two-digit 7-segment scan controller with frame-aligned load/ack handshake.
// Optional SEG_SCAN_LD_MIRROR_EN adds the o_ld debug LED mirror output.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_blank,
  input  logic             i_load,
  input  logic [3:0]       i_digit0,
  input  logic [3:0]       i_digit1,
`ifdef SEG_SCAN_LD_MIRROR_EN
  output logic [SEG_W:0]   o_ld,
`endif
  output logic             o_ack,
  output logic             o_pending,
  output logic [SEG_W-1:0] o_digitalTube,
  output logic             o_sel
);

  localparam int unsigned      CNT_W    = $clog2(SCAN_DIV + 1);
  localparam int unsigned      SHOW_LEN = SCAN_DIV - BLANK_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(SHOW_LEN);
  localparam logic [SEG_W-1:0] SEG_OFF  = SEG_ACTIVE_LOW ? ~SEG_ALL_OFF : SEG_ALL_OFF;

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             was_idle_q;
  digit_pair_t      shadow_q, active_q;
  logic             commit_c;
  logic [3:0]       digit_c;
  logic [SEG_W-1:0] dec_seg_c;
  logic [SEG_W-1:0] seg_d;

  assign digit_c = sel_q ? active_q.d1 : active_q.d0;

  seven_seg_hex_decode #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_decode (
    .digit(digit_c),
    .seg_c(dec_seg_c)
  );

  // Slot sequencing, commit decision and next pin values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    commit_c = 1'b0;
    seg_d    = SEG_OFF;

    if (!i_enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      sel_d   = 1'b0;
    end else begin
      if (state_q == IDLE) begin
        cnt_d = '0;
        sel_d = 1'b0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        sel_d = ~sel_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      state_d = (cnt_d < CNT_SHOW) ? SHOW : GUARD;
    end

    // Frame boundary, or first IDLE cycle so a waiting ack is not stranded
    if (o_pending) begin
      if (state_q == IDLE) begin
        commit_c = !was_idle_q;
      end else begin
        commit_c = (cnt_q == CNT_LAST) && sel_q;
      end
    end

    if ((state_q == SHOW) && !i_blank) begin
      seg_d = dec_seg_c;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sel_q         <= 1'b0;
      was_idle_q    <= 1'b1;
      shadow_q      <= '0;
      active_q      <= '0;
      o_pending     <= 1'b0;
      o_ack         <= 1'b0;
      o_digitalTube <= SEG_OFF;
      o_sel         <= 1'b0;
`ifdef SEG_SCAN_LD_MIRROR_EN
      o_ld          <= {1'b0, SEG_OFF};
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      was_idle_q <= (state_q == IDLE);
      if (i_load) begin
        shadow_q.d1 <= i_digit1;
        shadow_q.d0 <= i_digit0;
      end
      // Commit takes the shadow as it was before any same-cycle load
      if (commit_c) begin
        active_q <= shadow_q;
      end
      o_pending     <= i_load | (o_pending & ~commit_c);
      o_ack         <= commit_c;
      o_digitalTube <= seg_d;
      o_sel         <= sel_q;
`ifdef SEG_SCAN_LD_MIRROR_EN
      o_ld          <= {sel_q, seg_d};
`endif
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl: vector table plus load/ack scoreboard.
module tb_seven_seg_scan_ctrl;

  localparam int unsigned SD = 8;
  localparam int unsigned BC = 2;

  typedef struct {
    logic [3:0] d0;
    logic [3:0] d1;
    logic [6:0] s0;
    logic [6:0] s1;
  } vec_t;

  typedef struct {
    logic [6:0] seg0;
    logic [6:0] seg1;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       al_rst_n;
  logic       enable;
  logic       blank;
  logic       load;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic       ack, pend, sel;
  logic [6:0] seg;
  logic       al_ack, al_pend, al_sel;
  logic [6:0] al_seg;
`ifdef SEG_SCAN_LD_MIRROR_EN
  logic [7:0] ld, al_ld;
`endif

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];
  vec_t vecs[8];

  seven_seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .SEG_ACTIVE_LOW(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_blank(blank),
    .i_load(load), .i_digit0(digit0), .i_digit1(digit1),
`ifdef SEG_SCAN_LD_MIRROR_EN
    .o_ld(ld),
`endif
    .o_ack(ack), .o_pending(pend), .o_digitalTube(seg), .o_sel(sel)
  );

  seven_seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .SEG_ACTIVE_LOW(1'b1)) dut_al (
    .i_clk(clk), .i_rst_n(al_rst_n), .i_enable(enable), .i_blank(blank),
    .i_load(load), .i_digit0(digit0), .i_digit1(digit1),
`ifdef SEG_SCAN_LD_MIRROR_EN
    .o_ld(al_ld),
`endif
    .o_ack(al_ack), .o_pending(al_pend), .o_digitalTube(al_seg), .o_sel(al_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [3:0] d0, input logic [3:0] d1, input bit replace);
    exp_t e;
    e.seg0 = 7'h00;
    e.seg1 = 7'h00;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].d0 == d0) e.seg0 = vecs[i].s0;
      if (vecs[i].d1 == d0) e.seg0 = vecs[i].s1;
      if (vecs[i].d0 == d1) e.seg1 = vecs[i].s0;
      if (vecs[i].d1 == d1) e.seg1 = vecs[i].s1;
    end
    if (replace && sb.size() > 0) void'(sb.pop_back());
    sb.push_back(e);
    load   = 1'b1;
    digit0 = d0;
    digit1 = d1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic sync_frame(input string tag);
    bit got1 = 1'b0;
    bit got0 = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (sel) begin got1 = 1'b1; break; end
      @(negedge clk);
    end
    for (int n = 0; n < 20; n++) begin
      if (!sel) begin got0 = 1'b1; break; end
      @(negedge clk);
    end
    chk({tag, "_sync"}, {31'd0, got1 & got0}, 32'd1);
  endtask

  task automatic wait_ack(input logic exp_pend, input string tag, output int ack_cyc);
    bit   seen = 1'b0;
    bit   held = 1'b1;
    exp_t e;
    ack_cyc = 0;
    for (int n = 0; n < 2 * SD + 4; n++) begin
      if (ack) begin seen = 1'b1; break; end
      if (!pend) held = 1'b0;
      @(negedge clk);
    end
    ack_cyc = cyc;
    chk({tag, "_ack_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_pend_held"}, {31'd0, held}, 32'd1);
    chk({tag, "_pend_after"}, {31'd0, pend}, {31'd0, exp_pend});
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      e.seg0 = 7'h00;
      e.seg1 = 7'h00;
    end else begin
      e = sb.pop_front();
    end
    @(negedge clk);
    chk({tag, "_ack_width"}, {31'd0, ack}, 32'd0);
    chk({tag, "_seg0"}, {25'd0, seg}, {25'd0, e.seg0});
    chk({tag, "_sel0"}, {31'd0, sel}, 32'd0);
    repeat (SD) @(negedge clk);
    chk({tag, "_seg1"}, {25'd0, seg}, {25'd0, e.seg1});
    chk({tag, "_sel1"}, {31'd0, sel}, 32'd1);
  endtask

  task automatic expect_no_ack(input int n, input string tag);
    bit any = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (ack) any = 1'b1;
    end
    chk(tag, {31'd0, any}, 32'd0);
  endtask

  initial begin
    logic [6:0] exp_s;
    logic       exp_l;
    int         c, t0, ack_a, ack_b;
    bit         seg_ok, al_ok, seen;
    int         toggles;
    logic       prev_sel;
    exp_t       e;

    vecs[0] = '{d0: 4'hA, d1: 4'h8, s0: 7'h77, s1: 7'h7F};
    vecs[1] = '{d0: 4'h0, d1: 4'h1, s0: 7'h3F, s1: 7'h06};
    vecs[2] = '{d0: 4'h2, d1: 4'h3, s0: 7'h5B, s1: 7'h4F};
    vecs[3] = '{d0: 4'h4, d1: 4'h5, s0: 7'h66, s1: 7'h6D};
    vecs[4] = '{d0: 4'h6, d1: 4'h7, s0: 7'h7D, s1: 7'h07};
    vecs[5] = '{d0: 4'h9, d1: 4'hB, s0: 7'h6F, s1: 7'h7C};
    vecs[6] = '{d0: 4'hC, d1: 4'hD, s0: 7'h39, s1: 7'h5E};
    vecs[7] = '{d0: 4'hE, d1: 4'hF, s0: 7'h79, s1: 7'h71};

    rst_n = 1'b0; al_rst_n = 1'b0;
    enable = 1'b1; blank = 1'b0; load = 1'b0;
    digit0 = 4'h0; digit1 = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_seg", {25'd0, seg}, 32'h00);
    chk("rst_sel", {31'd0, sel}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_pend", {31'd0, pend}, 32'd0);
    chk("rst_al_seg", {25'd0, al_seg}, 32'h7F);
`ifdef SEG_SCAN_LD_MIRROR_EN
    chk("rst_ld", {24'd0, ld}, 32'h00);
`endif
    rst_n = 1'b1; al_rst_n = 1'b1;

    // Startup: one IDLE cycle, then 6 lit / 2 blank per slot
    for (int k = 1; k <= 2 * SD + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        exp_s = 7'h00;
        exp_l = 1'b0;
      end else begin
        c     = (k - 2) % SD;
        exp_l = 1'(((k - 2) / SD) % 2);
        exp_s = (c < int'(SD - BC)) ? 7'h3F : 7'h00;
      end
      chk("start_seg", {25'd0, seg}, {25'd0, exp_s});
      chk("start_sel", {31'd0, sel}, {31'd0, exp_l});
    end

    for (int i = 0; i < 8; i++) begin
      sync_frame("vec");
      do_load(vecs[i].d0, vecs[i].d1, 1'b0);
      chk("vec_pend_set", {31'd0, pend}, 32'd1);
      wait_ack(1'b0, "vec", ack_a);
    end

    // Two loads in one frame: only the later value commits, one ack
    sync_frame("dbl");
    do_load(4'h1, 4'h2, 1'b0);
    do_load(4'h3, 4'h4, 1'b1);
    wait_ack(1'b0, "dbl", ack_a);
    expect_no_ack(2 * SD + 2, "dbl_single_ack");

    // Load landing on the commit cycle rolls into the next frame
    sync_frame("cc");
    do_load(4'h2, 4'h9, 1'b0);
    repeat (13) @(negedge clk);
    t0 = cyc;
    do_load(4'hF, 4'h0, 1'b0);
    wait_ack(1'b1, "cc_first", ack_a);
    wait_ack(1'b0, "cc_second", ack_b);
    chk("cc_latency", ack_b - t0, 2 * SD + 1);

    // Blank: segments off while selection keeps scanning
    sync_frame("blank");
    blank = 1'b1;
    @(negedge clk);
    seg_ok = 1'b1; al_ok = 1'b1; toggles = 0; prev_sel = 1'b0;
    for (int k = 1; k <= 2 * SD; k++) begin
      @(negedge clk);
      if (seg !== 7'h00) seg_ok = 1'b0;
      if (al_seg !== 7'h7F) al_ok = 1'b0;
      if (sel !== prev_sel) toggles++;
      prev_sel = sel;
    end
    chk("blank_seg_off", {31'd0, seg_ok}, 32'd1);
    chk("blank_al_seg_off", {31'd0, al_ok}, 32'd1);
    chk("blank_sel_toggles", toggles, 2);
    blank = 1'b0;

    // Disable with a pending load: ack on first IDLE cycle, restart at slot 0
    sync_frame("idle");
    do_load(4'h5, 4'h6, 1'b0);
    enable = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (ack) begin seen = 1'b1; break; end
    end
    chk("idle_ack_seen", {31'd0, seen}, 32'd1);
    chk("idle_pend_clr", {31'd0, pend}, 32'd0);
    e = sb.pop_front();
    repeat (2) @(negedge clk);
    chk("idle_seg_off", {25'd0, seg}, 32'h00);
    chk("idle_sel0", {31'd0, sel}, 32'd0);
    expect_no_ack(4, "idle_single_ack");
    enable = 1'b1;
    repeat (2) @(negedge clk);
    chk("reen_seg0", {25'd0, seg}, {25'd0, e.seg0});
    chk("reen_sel0", {31'd0, sel}, 32'd0);
    repeat (SD) @(negedge clk);
    chk("reen_seg1", {25'd0, seg}, {25'd0, e.seg1});
    chk("reen_sel1", {31'd0, sel}, 32'd1);

    // Active-low instance: async reset mid-slot, no clock edge needed
    @(negedge clk);
    chk("al_lit_seg", {25'd0, al_seg}, 32'h02);
    chk("al_lit_sel", {31'd0, al_sel}, 32'd1);
    #2 al_rst_n = 1'b0;
    #1;
    chk("al_arst_seg", {25'd0, al_seg}, 32'h7F);
    chk("al_arst_sel", {31'd0, al_sel}, 32'd0);
    chk("al_arst_ack", {31'd0, al_ack}, 32'd0);
    chk("al_arst_pend", {31'd0, al_pend}, 32'd0);
`ifdef SEG_SCAN_LD_MIRROR_EN
    chk("al_arst_ld", {24'd0, al_ld}, 32'h7F);
`endif
    @(negedge clk);
    al_rst_n = 1'b1;

    // Reset while a load is pending discards it
    sync_frame("rstp");
    do_load(4'h7, 4'h7, 1'b0);
    chk("rstp_pend_set", {31'd0, pend}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstp_pend_clr", {31'd0, pend}, 32'd0);
    chk("rstp_seg_off", {25'd0, seg}, 32'h00);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstp_seg_zero", {25'd0, seg}, 32'h3F);
    chk("rstp_sel", {31'd0, sel}, 32'd0);
    expect_no_ack(2 * SD + 4, "rstp_no_ack");
    chk("rstp_pend_still_clr", {31'd0, pend}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
